// File: rtl/clk_ratio_meter.sv
// Measures period and high time of an asynchronous divided clock in ref_clk cycles.
// Optional odd/even duty symmetry check enabled by defining MEAS_DUTY_CHK_EN.
module clk_ratio_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             ref_clk,
  input  logic             rst,
  input  logic             meas_En,
  input  logic             Meas_Clk,
  output logic [CNT_W-1:0] Meas_rat,
  output logic [CNT_W-1:0] High_cnt,
  output logic             meas_valid,
  output logic             meas_ovf,
  output logic             Duty_err
);

  // state | meaning
  // IDLE  | disabled, counters cleared, results held
  // ARM   | waiting for the first rising edge
  // MEAS  | counting a period, capture on each rising edge
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s, s_d, rise;
  logic [CNT_W-1:0]       per_cnt, hi_cnt;

  logic cnt_clr, cnt_load, cnt_inc, hi_inc, cap, ovf_hit;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  // The synchronizer runs regardless of meas_En so edges are clean on re-enable.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Meas_Clk};
      s_d    <= s;
    end
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    hi_inc   = 1'b0;
    cap      = 1'b0;
    ovf_hit  = 1'b0;
    if (!meas_En) begin
      state_d = IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_clr = 1'b1;
        end
        ARM: begin
          // Counting here too, so a stuck input still flags overflow.
          if (rise) begin
            cnt_load = 1'b1;
            state_d  = MEAS;
          end else if (per_cnt == CNT_MAX) begin
            ovf_hit = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        MEAS: begin
          if (rise) begin
            cap      = 1'b1;
            cnt_load = 1'b1;
          end else if (per_cnt == CNT_MAX) begin
            ovf_hit = 1'b1;
            cnt_clr = 1'b1;
            state_d = ARM;
          end else begin
            cnt_inc = 1'b1;
            hi_inc  = s;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (cnt_clr) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (cnt_load) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else if (cnt_inc) begin
      per_cnt <= per_cnt + CNT_W'(1);
      if (hi_inc) hi_cnt <= hi_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      Meas_rat   <= '0;
      High_cnt   <= '0;
      meas_valid <= 1'b0;
      meas_ovf   <= 1'b0;
    end else begin
      meas_valid <= cap;
      if (cap) begin
        Meas_rat <= per_cnt;
        High_cnt <= hi_cnt;
      end
      if (!meas_En)     meas_ovf <= 1'b0;
      else if (ovf_hit) meas_ovf <= 1'b1;
    end
  end

`ifdef MEAS_DUTY_CHK_EN
  logic [CNT_W:0] two_hi, per_x, duty_diff;
  logic           duty_bad;

  // Extra bit keeps 2*high from wrapping.
  always_comb begin
    two_hi    = {hi_cnt, 1'b0};
    per_x     = {1'b0, per_cnt};
    duty_diff = (two_hi >= per_x) ? (two_hi - per_x) : (per_x - two_hi);
    duty_bad  = (duty_diff > (CNT_W+1)'(1));
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst)      Duty_err <= 1'b0;
    else if (cap) Duty_err <= duty_bad;
  end
`else
  assign Duty_err = 1'b0;
`endif

endmodule
